command_pack: RTL and testbench
===============================

# command_pack

Transmit-side framer for the byte-wide command link. It packs a 16-bit command code and 0..MAX_WORDS 32-bit data words into one contiguous byte frame, MSB byte first. The frame format is command high byte, command low byte, then four bytes per word. Upstream logic (DDR readback, register readback, status reporting) hands over a command and its words; this block buffers them and emits the frame as an unbroken valid burst with an enforced inter-frame gap, so a link-side command decoder delimits frames purely by valid edges.

## Interface
- TCQ, 0.1, simulation clock-to-Q delay on all registered assignments
- COMMAND_WIDTH, 16, command code width (fixed 16 for this framing)
- MAX_WORDS, 16, word buffer depth; power of two, 2..256
- GAP_CYCLES, 4, minimum idle cycles with valid low between frames; at least 1
- clk_sys_i  in  1  system clock; single clock domain
- rst_i  in  1  synchronous, active-high reset
- msg_start_i  in  1  one-cycle request to send a frame; accepted only in IDLE
- msg_cmd_i  in  16  command code; sampled with msg_start_i
- msg_len_i  in  9  number of data words; sampled with msg_start_i
- msg_data_vld_i  in  1  data word valid
- msg_data_i  in  32  data word
- msg_data_rdy_o  out  1  block accepts a word this cycle (vld && rdy = transfer)
- master_tx_data_vld_o  out  1  byte valid; high for the whole frame, no holes
- master_tx_data_o  out  8  frame byte; 0 whenever valid is low
- busy_o  out  1  high from start accept until the end of the gap
- msg_done_o  out  1  one-cycle pulse on the first cycle after the last frame byte
- msg_drop_o  out  1  one-cycle pulse when msg_start_i arrives while busy_o is high

## Operation
- States: IDLE, LOAD, HDR, DATA, GAP.
- **IDLE**
  - On msg_start_i, latch msg_cmd_i and the effective length N. N = min(msg_len_i, MAX_WORDS); the clamp is silent.
  - If N = 0, go to HDR. Otherwise go to LOAD.
- **LOAD**
  - msg_data_rdy_o = 1. Each handshake writes one word into the buffer (write pointer increments).
  - When word N is accepted, go to HDR. msg_data_rdy_o drops on the cycle after that final handshake.
  - Upstream stalls (vld low) simply extend LOAD. Nothing goes out on the link during LOAD.
- **HDR**
  - Emit cmd[15:8], then cmd[7:0], one per cycle.
  - Then go to DATA, or to GAP if N = 0.
- **DATA**
  - For each word, read it from the buffer and emit bytes [31:24], [23:16], [15:8], [7:0] on consecutive cycles.
  - A 2-bit byte counter and a word counter track position.
  - The buffer read is pipelined so there is never a bubble between words.
  - After byte 4 of word N, go to GAP.
- **GAP**
  - Valid is low.
  - Count GAP_CYCLES cycles, then return to IDLE; busy_o falls on entry to IDLE.
- Frame length is 2 + 4N bytes. Because valid is contiguous, the link decoder resynchronises on every rising edge of valid.
- msg_start_i while busy_o is high: ignored, msg_drop_o pulses, and the current frame is unaffected.
- msg_data_vld_i outside LOAD: ignored (rdy is low).
- Pointers reset to 0 at every start. The buffer holds exactly one frame, so there is no wrap-around.
- Reset mid-operation:
  - The next cycle is IDLE with all outputs at their reset values and pointers cleared.
  - A truncated frame ends with valid low, which the decoder discards.
  - Words in flight are lost.
- Reset values: msg_data_rdy_o 0, master_tx_data_vld_o 0, master_tx_data_o 0, busy_o 0, msg_done_o 0, msg_drop_o 0.

## Timing
- Start accepted at cycle T with N > 0: msg_data_rdy_o = 1 from T+1.
- Last word handshake at cycle L: first header byte with valid = 1 at L+1. Last byte at L+2+4N. msg_done_o at L+3+4N.
- Start at T with N = 0: header bytes at T+1 and T+2, msg_done_o at T+3.
- Best-case latency with no upstream stalls: T+N+1.
- GAP occupies the GAP_CYCLES cycles beginning with the msg_done_o cycle. busy_o is high from T+1 through the last gap cycle.
- A start presented on the first IDLE cycle is accepted. Its first valid byte therefore comes at least GAP_CYCLES+1 cycles after the previous frame's last byte.
- All outputs are registered.

## Test plan
- Single word: start with cmd 0x1001, len 1, word 0x12345678 presented at T+1.
  - Required: bytes 10 01 12 34 56 78 with valid high for exactly 6 consecutive cycles, data 0 before and after.
  - Required: msg_done_o one cycle after byte 0x78, busy_o low GAP_CYCLES cycles later.
- Header only: cmd 0x1003, len 0.
  - Required: bytes 10 03 at T+1 and T+2, then valid low, msg_done_o at T+3.
- Upstream stalls: len 3, words 0xA0A1A2A3, 0xB0B1B2B3, 0xC0C1C2C3, with vld low for 5 cycles between words.
  - Required: frame begins after the third handshake, then 14 contiguous bytes, correct order.
- Back-to-back requests:
  - Start pulsed while busy → msg_drop_o pulse; the ongoing frame is bit-exact.
  - Start pulsed on the first IDLE cycle after a frame → accepted; at least GAP_CYCLES low-valid cycles separate the two frames.
- Clamp and full buffer: len 20 with MAX_WORDS 16, words 0..15 incrementing.
  - Required: exactly 16 handshakes, 66 contiguous bytes; the 17th word offered is not accepted.
- Reset mid-frame: rst_i asserted during DATA word 2.
  - Required: valid low and all outputs at reset values the next cycle.
  - Required: a following 1-word frame is correct.
  - Loopback into the command decoder: cmd 0x1003 with data 0x00000001 sets the raw ADC config bit, and the truncated frame causes no decoder action.

Source files
------------

// File: rtl/command_pack_if.sv
// Message-side and link-side signal bundle for the command_pack framer.
// The master modport belongs to the upstream producer; slave belongs to the framer.
interface command_pack_if #(
  parameter int COMMAND_WIDTH = 16
);
  logic                     msg_start_i;
  logic [COMMAND_WIDTH-1:0] msg_cmd_i;
  logic [8:0]               msg_len_i;
  logic                     msg_data_vld_i;
  logic [31:0]              msg_data_i;
  logic                     msg_data_rdy_o;
  logic                     master_tx_data_vld_o;
  logic [7:0]               master_tx_data_o;
  logic                     busy_o;
  logic                     msg_done_o;
  logic                     msg_drop_o;

  modport master (
    output msg_start_i, msg_cmd_i, msg_len_i, msg_data_vld_i, msg_data_i,
    input  msg_data_rdy_o, master_tx_data_vld_o, master_tx_data_o,
    input  busy_o, msg_done_o, msg_drop_o
  );

  modport slave (
    input  msg_start_i, msg_cmd_i, msg_len_i, msg_data_vld_i, msg_data_i,
    output msg_data_rdy_o, master_tx_data_vld_o, master_tx_data_o,
    output busy_o, msg_done_o, msg_drop_o
  );
endinterface

// File: rtl/command_pack.sv
// Byte-wide command link framer: buffers a command plus up to MAX_WORDS words and
// emits them as one gap-free valid burst (cmd hi, cmd lo, words MSB first).
module command_pack #(
  parameter int COMMAND_WIDTH = 16,
  parameter int MAX_WORDS     = 16,
  parameter int GAP_CYCLES    = 4
) (
  input  logic          clk_sys_i,
  input  logic          rst_i,
  command_pack_if.slave link
);

  localparam int LEN_W = 9;
  localparam int AW    = $clog2(MAX_WORDS);
  localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_WORDS);
  localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HDR  = 3'd2,
    ST_DATA = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      2'd3:    b = word[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_t                   state_r, state_s;
  logic [COMMAND_WIDTH-1:0] cmd_r, cmd_s;
  logic [LEN_W-1:0]         len_r, len_s;
  logic [LEN_W-1:0]         len_clamp_s;
  logic [LEN_W-1:0]         wr_cnt_r, wr_cnt_s;
  logic [LEN_W-1:0]         word_cnt_r, word_cnt_s;
  logic [AW-1:0]            rd_ptr_r, rd_ptr_s;
  logic [1:0]               byte_cnt_r, byte_cnt_s;
  logic [GW-1:0]            gap_cnt_r, gap_cnt_s;
  logic [31:0]              cur_word_r, cur_word_s;
  logic [31:0]              rd_data_r;
  logic                     rdy_r, rdy_s;
  logic                     vld_r, vld_s;
  logic [7:0]               data_r, data_s;
  logic                     busy_r, busy_s;
  logic                     done_r, done_s;
  logic                     drop_r, drop_s;
  logic                     wr_en_s;
  logic [31:0]              buf_mem [MAX_WORDS];

  // Length clamp applied silently when a start is accepted
  always_comb begin
    if (link.msg_len_i > MAX_LEN) begin
      len_clamp_s = MAX_LEN;
    end else begin
      len_clamp_s = link.msg_len_i;
    end
  end

  assign wr_en_s = (state_r == ST_LOAD) && rdy_r && link.msg_data_vld_i;

  // Word buffer with registered read; the next word is prefetched while the
  // current word's bytes go out, so words follow each other without a bubble.
  always_ff @(posedge clk_sys_i) begin
    if (wr_en_s) begin
      buf_mem[wr_cnt_r[AW-1:0]] <= link.msg_data_i;
    end
    rd_data_r <= buf_mem[rd_ptr_r];
  end

  // Next-state and next-output logic; every output is the registered copy of these
  always_comb begin
    state_s    = state_r;
    cmd_s      = cmd_r;
    len_s      = len_r;
    wr_cnt_s   = wr_cnt_r;
    word_cnt_s = word_cnt_r;
    rd_ptr_s   = rd_ptr_r;
    byte_cnt_s = byte_cnt_r;
    gap_cnt_s  = gap_cnt_r;
    cur_word_s = cur_word_r;
    rdy_s      = 1'b0;
    vld_s      = 1'b0;
    data_s     = 8'h00;
    busy_s     = busy_r;
    done_s     = 1'b0;
    drop_s     = link.msg_start_i && busy_r;

    case (state_r)
      ST_IDLE: begin
        if (link.msg_start_i) begin
          cmd_s      = link.msg_cmd_i;
          len_s      = len_clamp_s;
          wr_cnt_s   = '0;
          word_cnt_s = '0;
          rd_ptr_s   = '0;
          byte_cnt_s = 2'd0;
          busy_s     = 1'b1;
          if (len_clamp_s == '0) begin
            state_s = ST_HDR;
            vld_s   = 1'b1;
            data_s  = link.msg_cmd_i[COMMAND_WIDTH-1 -: 8];
          end else begin
            state_s = ST_LOAD;
            rdy_s   = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_LOAD: begin
        rdy_s = 1'b1;
        if (link.msg_data_vld_i) begin
          wr_cnt_s = wr_cnt_r + LEN_W'(1);
          if (wr_cnt_r == len_r - LEN_W'(1)) begin
            state_s    = ST_HDR;
            rdy_s      = 1'b0;
            vld_s      = 1'b1;
            data_s     = cmd_r[COMMAND_WIDTH-1 -: 8];
            byte_cnt_s = 2'd0;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end

      ST_HDR: begin
        if (byte_cnt_r == 2'd0) begin
          vld_s      = 1'b1;
          data_s     = cmd_r[7:0];
          byte_cnt_s = 2'd1;
        end else if (len_r == '0) begin
          state_s   = ST_GAP;
          done_s    = 1'b1;
          gap_cnt_s = '0;
        end else begin
          state_s    = ST_DATA;
          vld_s      = 1'b1;
          data_s     = rd_data_r[31:24];
          cur_word_s = rd_data_r;
          rd_ptr_s   = rd_ptr_r + AW'(1);
          byte_cnt_s = 2'd0;
          word_cnt_s = '0;
        end
      end

      ST_DATA: begin
        if (byte_cnt_r != 2'd3) begin
          vld_s      = 1'b1;
          data_s     = byte_sel(cur_word_r, byte_cnt_r + 2'd1);
          byte_cnt_s = byte_cnt_r + 2'd1;
        end else if (word_cnt_r == len_r - LEN_W'(1)) begin
          state_s   = ST_GAP;
          done_s    = 1'b1;
          gap_cnt_s = '0;
        end else begin
          vld_s      = 1'b1;
          data_s     = rd_data_r[31:24];
          cur_word_s = rd_data_r;
          rd_ptr_s   = rd_ptr_r + AW'(1);
          word_cnt_s = word_cnt_r + LEN_W'(1);
          byte_cnt_s = 2'd0;
        end
      end

      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
        end else begin
          gap_cnt_s = gap_cnt_r + GW'(1);
        end
      end

      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, counters and output registers with synchronous reset
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      cmd_r      <= '0;
      len_r      <= '0;
      wr_cnt_r   <= '0;
      word_cnt_r <= '0;
      rd_ptr_r   <= '0;
      byte_cnt_r <= 2'd0;
      gap_cnt_r  <= '0;
      cur_word_r <= 32'h0000_0000;
      rdy_r      <= 1'b0;
      vld_r      <= 1'b0;
      data_r     <= 8'h00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      drop_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cmd_r      <= cmd_s;
      len_r      <= len_s;
      wr_cnt_r   <= wr_cnt_s;
      word_cnt_r <= word_cnt_s;
      rd_ptr_r   <= rd_ptr_s;
      byte_cnt_r <= byte_cnt_s;
      gap_cnt_r  <= gap_cnt_s;
      cur_word_r <= cur_word_s;
      rdy_r      <= rdy_s;
      vld_r      <= vld_s;
      data_r     <= data_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      drop_r     <= drop_s;
    end
  end

  assign link.msg_data_rdy_o       = rdy_r;
  assign link.master_tx_data_vld_o = vld_r;
  assign link.master_tx_data_o     = data_r;
  assign link.busy_o               = busy_r;
  assign link.msg_done_o           = done_r;
  assign link.msg_drop_o           = drop_r;

endmodule

// File: tb/tb_command_pack.sv
// Directed bench for command_pack: table-driven frames plus hand-written sequences
// for drop, back-to-back start, length clamp and mid-frame reset.
module tb_command_pack;

  localparam int GAP = 4;

  typedef struct packed {
    logic [15:0]  cmd;
    logic [8:0]   len;
    logic [7:0]   stall;
    logic [127:0] words;
    logic [7:0]   nbytes;
    logic [111:0] bytes;
  } vec_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        vld;
    logic [7:0]  data;
    logic        hs;
    logic        done;
    logic        drop;
    logic        busy;
  } mon_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;
  int   done_total = 0;
  int   prev_first = 0;
  int   prev_last = 0;
  mon_t log_q[$];
  logic [31:0] words_a [20];
  logic [7:0]  exp_a [66];
  vec_t vecs [5];

  command_pack_if #(.COMMAND_WIDTH(16)) bus ();

  command_pack #(
    .COMMAND_WIDTH(16),
    .MAX_WORDS(16),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk_sys_i(clk),
    .rst_i(rst),
    .link(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle record of every DUT output, sampled mid-cycle
  always @(negedge clk) begin
    log_q.push_back({32'(cyc), bus.master_tx_data_vld_o, bus.master_tx_data_o,
                     bus.msg_data_rdy_o & bus.msg_data_vld_i, bus.msg_done_o,
                     bus.msg_drop_o, bus.busy_o});
    if (bus.msg_done_o) done_total <= done_total + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic feed_words(input int offer, input int stall);
    for (int j = 0; j < offer; j++) begin
      bit acc;
      acc = 1'b0;
      bus.msg_data_vld_i = 1'b1;
      bus.msg_data_i     = words_a[j];
      for (int w = 0; w < 100 && !acc; w++) begin
        @(negedge clk);
        acc = bus.msg_data_rdy_o;
        @(posedge clk);
        #1;
      end
      bus.msg_data_vld_i = 1'b0;
      bus.msg_data_i     = 32'h0;
      if (!acc) break;
      if (j < offer - 1) begin
        repeat (stall) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic run_frame(input string tag, input logic [15:0] cmd, input logic [8:0] len,
                           input int offer, input int stall, input int n_exp,
                           input bit inject, input bit b2b);
    int idx0, done0, t_start, first_c, last_c, last_hs, rises, hs_n, done_n, drop_n;
    int done_c, busy_low, zero_bad, nexp_b;
    bit got_done;
    logic prev;
    mon_t m;
    logic [7:0] got[$];
    idx0  = log_q.size();
    done0 = done_total;
    @(posedge clk); #1;
    bus.msg_start_i = 1'b1;
    bus.msg_cmd_i   = cmd;
    bus.msg_len_i   = len;
    t_start = cyc;
    @(posedge clk); #1;
    bus.msg_start_i = 1'b0;
    feed_words(offer, stall);
    if (inject) begin
      @(posedge clk); #1;
      bus.msg_start_i = 1'b1;
      bus.msg_cmd_i   = 16'hFFFF;
      bus.msg_len_i   = 9'd0;
      @(posedge clk); #1;
      bus.msg_start_i = 1'b0;
    end
    got_done = 1'b0;
    for (int w = 0; w < 400 && !got_done; w++) begin
      if (done_total > done0) begin
        got_done = 1'b1;
      end else begin
        @(negedge clk); #1;
      end
    end
    chk({tag, ".done_seen"}, 32'(got_done), 32'd1);
    if (b2b) repeat (GAP - 1) @(negedge clk);
    else     repeat (GAP + 2) @(negedge clk);
    #1;

    first_c = -1; last_c = -1; last_hs = -1; rises = 0; hs_n = 0; done_n = 0;
    drop_n = 0; done_c = -1; busy_low = -1; zero_bad = 0; prev = 1'b0;
    for (int i = idx0; i < log_q.size(); i++) begin
      m = log_q[i];
      if (m.vld) begin
        got.push_back(m.data);
        if (!prev) rises++;
        if (first_c < 0) first_c = int'(m.cyc);
        last_c = int'(m.cyc);
      end else if (m.data != 8'h00) begin
        zero_bad++;
      end
      prev = m.vld;
      if (m.hs) begin hs_n++; last_hs = int'(m.cyc); end
      if (m.done) begin done_n++; if (done_c < 0) done_c = int'(m.cyc); end
      if (m.drop) drop_n++;
      if (done_c >= 0 && !m.busy && busy_low < 0) busy_low = int'(m.cyc);
    end

    nexp_b = 2 + 4 * n_exp;
    chk({tag, ".handshakes"}, 32'(hs_n), 32'(n_exp));
    chk({tag, ".frame_len"}, 32'(got.size()), 32'(nexp_b));
    for (int k = 0; k < nexp_b; k++) begin
      chk($sformatf("%s.byte%0d", tag, k),
          (k < got.size()) ? {24'h0, got[k]} : 32'hDEAD_0000, {24'h0, exp_a[k]});
    end
    chk({tag, ".single_burst"}, 32'(rises), 32'd1);
    chk({tag, ".contiguous"}, 32'(last_c - first_c + 1), 32'(got.size()));
    chk({tag, ".first_byte_cycle"}, 32'(first_c), (n_exp == 0) ? 32'(t_start + 1) : 32'(last_hs + 1));
    chk({tag, ".done_count"}, 32'(done_n), 32'd1);
    chk({tag, ".done_cycle"}, 32'(done_c), 32'(last_c + 1));
    chk({tag, ".drops"}, 32'(drop_n), 32'(inject));
    chk({tag, ".zero_when_idle"}, 32'(zero_bad), 32'd0);
    if (!b2b) chk({tag, ".busy_fall"}, 32'(busy_low), 32'(done_c + GAP));
    prev_first = first_c;
    prev_last  = last_c;
  endtask

  task automatic load_vec(input vec_t v);
    int l, nb;
    l  = int'(v.len);
    nb = int'(v.nbytes);
    for (int j = 0; j < l; j++) words_a[j] = v.words[(l - 1 - j) * 32 +: 32];
    for (int k = 0; k < nb; k++) exp_a[k] = v.bytes[(nb - 1 - k) * 8 +: 8];
  endtask

  initial begin
    int a_last, nb;
    vecs[0] = '{16'h1001, 9'd1, 8'd0, 128'h12345678, 8'd6, 112'h1001_12345678};
    vecs[1] = '{16'h1003, 9'd0, 8'd0, 128'h0, 8'd2, 112'h1003};
    vecs[2] = '{16'hABCD, 9'd3, 8'd5, 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3, 8'd14,
                112'hABCD_A0A1A2A3_B0B1B2B3_C0C1C2C3};
    vecs[3] = '{16'h5AA5, 9'd2, 8'd1, 128'hDEADBEEF_00000001, 8'd10, 112'h5AA5_DEADBEEF_00000001};
    vecs[4] = '{16'h1003, 9'd1, 8'd0, 128'h00000001, 8'd6, 112'h1003_00000001};

    bus.msg_start_i = 1'b0; bus.msg_cmd_i = 16'h0; bus.msg_len_i = 9'd0;
    bus.msg_data_vld_i = 1'b0; bus.msg_data_i = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.outputs", {20'h0, bus.master_tx_data_vld_o, bus.master_tx_data_o, bus.msg_data_rdy_o,
        bus.busy_o, bus.msg_done_o, bus.msg_drop_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 5; i++) begin
      load_vec(vecs[i]);
      run_frame($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].len, int'(vecs[i].len),
                int'(vecs[i].stall), int'(vecs[i].len), 1'b0, 1'b0);
    end

    // Start while busy is dropped and the running frame stays intact
    words_a[0] = 32'hCAFEF00D;
    exp_a[0] = 8'h24; exp_a[1] = 8'h68; exp_a[2] = 8'hCA; exp_a[3] = 8'hFE;
    exp_a[4] = 8'hF0; exp_a[5] = 8'h0D;
    run_frame("drop", 16'h2468, 9'd1, 1, 0, 1, 1'b1, 1'b0);

    // Second start lands on the first IDLE cycle after the first frame's gap
    words_a[0] = 32'h01020304;
    exp_a[0] = 8'h11; exp_a[1] = 8'h11; exp_a[2] = 8'h01; exp_a[3] = 8'h02;
    exp_a[4] = 8'h03; exp_a[5] = 8'h04;
    run_frame("b2b_a", 16'h1111, 9'd1, 1, 0, 1, 1'b0, 1'b1);
    a_last = prev_last;
    exp_a[0] = 8'h22; exp_a[1] = 8'h22;
    run_frame("b2b_b", 16'h2222, 9'd0, 0, 0, 0, 1'b0, 1'b0);
    chk("b2b.spacing", 32'(prev_first - a_last), 32'(GAP + 2));

    // Length 20 clamps to 16; the 17th offered word must never be taken
    for (int j = 0; j < 20; j++) words_a[j] = 32'(j);
    exp_a[0] = 8'h20; exp_a[1] = 8'h14;
    for (int j = 0; j < 16; j++) begin
      exp_a[2 + 4 * j] = 8'h00; exp_a[3 + 4 * j] = 8'h00;
      exp_a[4 + 4 * j] = 8'h00; exp_a[5 + 4 * j] = 8'(j);
    end
    run_frame("clamp", 16'h2014, 9'd20, 17, 0, 16, 1'b0, 1'b0);

    // Reset during the second data word
    words_a[0] = 32'h11111111; words_a[1] = 32'h22222222; words_a[2] = 32'h33333333;
    @(posedge clk); #1;
    bus.msg_start_i = 1'b1; bus.msg_cmd_i = 16'h3333; bus.msg_len_i = 9'd3;
    @(posedge clk); #1;
    bus.msg_start_i = 1'b0;
    feed_words(3, 0);
    nb = 0;
    for (int w = 0; w < 100 && nb < 7; w++) begin
      @(negedge clk);
      if (bus.master_tx_data_vld_o) nb++;
    end
    chk("rst_mid.reached_word2", 32'(nb), 32'd7);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid.outputs", {20'h0, bus.master_tx_data_vld_o, bus.master_tx_data_o, bus.msg_data_rdy_o,
        bus.busy_o, bus.msg_done_o, bus.msg_drop_o}, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_mid.stays_idle", {30'h0, bus.master_tx_data_vld_o, bus.busy_o}, 32'h0);

    load_vec(vecs[0]);
    run_frame("after_rst", vecs[0].cmd, vecs[0].len, 1, 0, 1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
